// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in the EX stage (radix-2, shift-add / restoring divide).
// Latency: fixed XLEN+2 cycles from accepted start to the done_o pulse, independent of op and data.
// Backpressure: busy_o stalls the pipeline in CALC/FIX; start_i is ignored unless the unit is IDLE.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  data1_i,
    input  logic [XLEN-1:0]  data2_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic [XLEN-1:0]   opa;          // multiplicand magnitude
    logic [XLEN-1:0]   opb;          // multiplier / divisor magnitude
    logic [XLEN-1:0]   dividend_raw; // original rs1, returned by REM on divide-by-zero
    logic [TAG_W-1:0]  tag_q;
    logic              neg_res;      // operand signs differ: negate product / quotient
    logic              neg_rem;      // dividend negative: negate remainder
    logic              div_zero;

    // Shared working register: product for multiply, {remainder, quotient} for divide.
    logic [2*XLEN:0]   acc;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     upper_sum;
    logic [XLEN:0]     rem_sh, rem_new;
    logic              q_bit;
    logic [2*XLEN:0]   mul_nxt, div_nxt;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    assign accept = (state == S_IDLE) && start_i && !flush_i;

    // Operand decode: signedness per op, magnitudes and sign flags of the incoming operands.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (funct3_i)
            3'b001, 3'b100, 3'b110: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            3'b010:  a_signed = 1'b1;
            default: ;
        endcase
        a_neg = a_signed && data1_i[XLEN-1];
        b_neg = b_signed && data2_i[XLEN-1];
        a_mag = a_neg ? -data1_i : data1_i;
        b_mag = b_neg ? -data2_i : data2_i;
    end

    // One radix-2 step for both algorithms; the op selects which one is kept.
    always_comb begin
        // Shift-add: add multiplicand to the upper half when the current multiplier bit is set.
        upper_sum = acc[2*XLEN:XLEN] + (acc[0] ? {1'b0, opa} : '0);
        mul_nxt   = {1'b0, upper_sum, acc[XLEN-1:1]};
        // Restoring divide: shift next dividend bit into the remainder, subtract if it fits.
        rem_sh    = acc[2*XLEN-1:XLEN-1];
        q_bit     = (rem_sh >= {1'b0, opb});
        rem_new   = q_bit ? (rem_sh - {1'b0, opb}) : rem_sh;
        div_nxt   = {rem_new, acc[XLEN-2:0], q_bit};
    end

    // Sign correction and result selection. Divide-by-zero is overridden here; signed
    // overflow falls out naturally (magnitude 2^(XLEN-1) negated is itself, remainder 0).
    always_comb begin
        prod_s  = neg_res ? -acc[2*XLEN-1:0] : acc[2*XLEN-1:0];
        quo_s   = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_s   = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_res = '0;
        case (op)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = div_zero ? '1 : quo_s;
            default:                fix_res = div_zero ? dividend_raw : rem_s;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        done_o    = 1'b0;
        case (state)
            S_IDLE: if (start_i && !flush_i) state_nxt = S_CALC;
            S_CALC: begin
                busy_o = 1'b1;
                if (flush_i)         state_nxt = S_IDLE;
                else if (cnt == '0)  state_nxt = S_FIX;
            end
            S_FIX: begin
                busy_o    = 1'b1;
                state_nxt = flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                done_o    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture on accept, then one iteration per CALC cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt          <= '0;
            op           <= '0;
            opa          <= '0;
            opb          <= '0;
            dividend_raw <= '0;
            tag_q        <= '0;
            neg_res      <= 1'b0;
            neg_rem      <= 1'b0;
            div_zero     <= 1'b0;
            acc          <= '0;
        end else if (accept) begin
            cnt          <= CW'(XLEN-1);
            op           <= funct3_i;
            opa          <= a_mag;
            opb          <= b_mag;
            dividend_raw <= data1_i;
            tag_q        <= tag_i;
            neg_res      <= a_neg ^ b_neg;
            neg_rem      <= a_neg;
            div_zero     <= (data2_i == '0);
            acc          <= {{(XLEN+1){1'b0}}, (funct3_i[2] ? a_mag : b_mag)};
        end else if (state == S_CALC) begin
            cnt <= cnt - 1'b1;
            acc <= op[2] ? div_nxt : mul_nxt;
        end
    end

    // Result/tag registers: written in FIX unless squashed, held until the next completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= '0;
            tag_o    <= '0;
        end else if (state == S_FIX && !flush_i) begin
            result_o <= fix_res;
            tag_o    <= tag_q;
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized + directed bench for ex_muldiv_unit with queue-based scoreboard.
// Latency: expects done_o exactly 34 cycles after the start cycle.
// Backpressure: issues only while idle; monitors done_o independently of stimulus.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  f3;
    logic [31:0] d1, d2;
    logic [4:0]  tag;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    ex_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .funct3_i (f3),
        .data1_i  (d1),
        .data2_i  (d2),
        .tag_i    (tag),
        .flush_i  (flush),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .tag_o    (tag_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_exp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Behavioural RV32M reference using plain 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sp, su, qs, rs;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        sp = sa * sb;
        su = sa * longint'({32'b0, b});
        case (op)
            3'd0: return up[31:0];
            3'd1: return sp[63:32];
            3'd2: return su[63:32];
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                qs = sa / sb;
                return qs[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                rs = sa % sb;
                return rs[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("spurious_done", {63'b0, done}, 64'd0);
            end else begin
                mon_e = q.pop_front();
                chk("result", {32'b0, result}, {32'b0, mon_e.res});
                chk("tag", {59'b0, tag_out}, {59'b0, mon_e.tag});
                chk("latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] t, input bit expect_done, input logic [31:0] expres,
                         output int s);
        exp_t e;
        @(negedge clk);
        f3 = op; d1 = a; d2 = b; tag = t; start = 1'b1;
        s = cyc;
        if (expect_done) begin
            e.res = expres; e.tag = t; e.cyc = cyc + 34;
            q.push_back(e);
            last_exp = expres;
        end
        @(negedge clk);
        start = 1'b0;
        d1 = $urandom; d2 = $urandom; tag = 5'($urandom); f3 = 3'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (q.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            chk("done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    localparam int ND = 16;
    logic [2:0]  dir_op  [ND] = '{3'd1, 3'd3, 3'd2, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd4, 3'd6};
    logic [31:0] dir_a   [ND] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd7, 32'd5, 32'd5, 32'd5, 32'd5, 32'hFFFF_FFF9,
                                  32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b   [ND] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'd2, 32'd2, 32'd7, 32'd7,
                                  32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_exp [ND] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF,
                                  32'h8000_0000, 32'd0};

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int s;
        int bad;
        logic [31:0] a, b, keep;
        logic [2:0]  op;

        rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = '0; d1 = '0; d2 = '0; tag = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_result", {32'b0, result}, 64'd0);
        chk("rst_tag", {59'b0, tag_out}, 64'd0);
        rst = 1'b0;

        // MUL 7x6: busy for 33 cycles, done in the 34th, result held afterwards.
        issue(3'd0, 32'd7, 32'd6, 5'd10, 1'b1, 32'd42, s);
        bad = 0;
        for (int k = 1; k <= 33; k++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("busy_window", 64'(bad), 64'd0);
        chk("busy_low_at_done", {63'b0, busy}, 64'd0);
        chk("done_at_34", {63'b0, done}, 64'd1);
        repeat (3) @(negedge clk);
        chk("result_hold", {32'b0, result}, 64'd42);
        chk("tag_hold", {59'b0, tag_out}, 64'd10);

        for (int i = 0; i < ND; i++) begin
            issue(dir_op[i], dir_a[i], dir_b[i], 5'(i + 1), 1'b1, dir_exp[i], s);
            wait_idle(60);
        end

        // Flush in the middle of a DIV: no completion, result untouched.
        keep = last_exp;
        issue(3'd4, 32'd1000, 32'd3, 5'd21, 1'b0, '0, s);
        while (cyc < s + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_result_kept", {32'b0, result}, {32'b0, keep});

        // Start pulse while busy is ignored.
        issue(3'd0, 32'd1234, 32'd5678, 5'd3, 1'b1, 32'd7006652, s);
        while (cyc < s + 5) @(negedge clk);
        f3 = 3'd4; d1 = 32'd99; d2 = 32'd3; tag = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(60);

        // Start together with flush in IDLE is dropped.
        @(negedge clk);
        f3 = 3'd0; d1 = 32'd3; d2 = 32'd3; tag = 5'd9; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("start_flush_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);

        // Reset in the middle of a MUL.
        issue(3'd0, 32'd99, 32'd77, 5'd12, 1'b0, '0, s);
        while (cyc < s + 20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {63'b0, busy}, 64'd0);
        chk("midrst_done", {63'b0, done}, 64'd0);
        chk("midrst_result", {32'b0, result}, 64'd0);
        chk("midrst_tag", {59'b0, tag_out}, 64'd0);
        issue(3'd5, 32'd100, 32'd7, 5'd30, 1'b1, 32'd14, s);
        wait_idle(60);

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = rand_operand();
            b  = rand_operand();
            issue(op, a, b, 5'($urandom), 1'b1, ref_model(op, a, b), s);
            wait_idle(60);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit that sits in the EX stage beside the ALU.
- The ID/EX-driven control issues one operation; the unit holds the pipeline via busy_o until the result is ready.
- The result and destination tag are then written back through EX/MEM.
- Parametrised in operand width and tag width; fixed, data-independent latency.

Parameters:
XLEN, 32, operand/result width in bits (even, >= 8)
TAG_W, 5, width of destination-register tag carried with the operation

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
start_i  input  1  issue request; sampled only while idle
funct3_i  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
data1_i  input  XLEN  rs1 operand (multiplicand / dividend)
data2_i  input  XLEN  rs2 operand (multiplier / divisor)
tag_i  input  TAG_W  destination register index (instr[11:7])
flush_i  input  1  abort current operation (branch/exception squash)
busy_o  output  1  high from the cycle after an accepted start until done_o
done_o  output  1  one-cycle pulse: result_o/tag_o valid
result_o  output  XLEN  result; held stable from done_o until the next accepted start
tag_o  output  TAG_W  tag of the completed operation; held like result_o

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; busy_o=0, done_o=0, result_o=0, tag_o=0. Reset overrides start_i and flush_i and aborts any in-flight operation.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE: on start_i=1 and flush_i=0, the unit latches funct3, operands and tag, then goes to CALC with iteration counter = XLEN-1.
  - For signed ops, it latches operand magnitudes and the sign flags.
  - MULHSU treats data1 as signed and data2 as unsigned.
- CALC: one radix-2 step per cycle; counter decrements and the state goes to FIX after the step with counter=0. Exactly XLEN cycles.
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring divide producing quotient and remainder.
- FIX (1 cycle): applies sign correction and selects the result.
  - Product is negated if the operand signs differ (signed ops).
  - Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
  - Registers result_o and tag_o; goes to DONE.
- DONE: done_o=1, busy_o=0 for that cycle, then IDLE.
  - A start_i asserted in the DONE cycle is ignored; the next accepted start is in IDLE.
- Latency: start accepted at edge T → done_o high during the cycle following edge T+XLEN+1, i.e. XLEN+2 cycles after acceptance (34 for XLEN=32). Latency is fixed for all ops and operand values.
- busy_o is high in CALC and FIX; start_i is ignored while busy.
- Special cases keep the same fixed latency and are resolved in FIX:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): DIV = most-negative, REM = 0.
- flush_i=1 in CALC or FIX: next state IDLE, busy_o=0 next cycle, no done_o, result_o/tag_o unchanged.
- flush_i=1 in the DONE cycle: done_o still pulses, because the result has already been produced and downstream squashes it.
- flush_i and start_i together in IDLE: flush wins and the start is dropped.
- All arithmetic is internally 2*XLEN+1 bits wide where needed; no truncation before FIX.

Test Plan:
- MUL 7×6, start at cycle 0 → busy_o 1 for cycles 1..33, done_o only in cycle 34, result_o=42, tag_o=tag_i (e.g. 5'd10) → result held until the next start.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF(-1)×0xFFFFFFFF → 0xFFFFFFFF; MUL 0xFFFFFFFF×0xFFFFFFFF → 0x00000001.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; REM 7/-2 → 1.
- DIV 5/0 → 0xFFFFFFFF, REM 5/0 → 5, DIVU 5/0 → 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM → 0; all done exactly 34 cycles after start.
- Flush and start rules:
  - flush_i at cycle 10 of a DIV → busy_o=0 at cycle 11, no done_o, result_o keeps its previous value.
  - start_i pulsed at cycle 5 while busy → ignored; the original op completes unchanged.
  - start_i+flush_i together in IDLE → no busy.
- rst_i asserted at cycle 20 of a MUL → next cycle busy_o=0, done_o=0, result_o=0, tag_o=0; a new op started afterwards completes in 34 cycles.
